// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step strobe driving COUNT/CHASE/BOUNCE/BLINK patterns.
// Optional `LED_PWM_EN` adds a duty_i input and registered PWM dimming of the LED outputs.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS = 5,
  parameter int unsigned TICK_DIV = 900000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic                clki_i,
  input  logic                reset_ni,
  input  logic [1:0]          mode_i,
  input  logic                pause_i,
`ifdef LED_PWM_EN
  input  logic [7:0]          duty_i,
`endif
  output logic                tick_o,
  output logic [NUM_LEDS-1:0] led_o
);

  typedef enum logic [1:0] {
    ModeCount  = 2'd0,
    ModeChase  = 2'd1,
    ModeBounce = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);
  localparam logic             DirUp  = 1'b0;
  localparam logic             DirDn  = 1'b1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  mode_e               cur_mode_q, cur_mode_d;
  logic                dir_q, dir_d;
  logic                tick;
  mode_e               mode_sel;

  assign mode_sel = mode_e'(mode_i);
  assign tick     = ~pause_i & (cnt_q == CntMax);
  assign tick_o   = tick;

  always_comb begin
    cnt_d = cnt_q;
    if (!pause_i) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pat_d      = pat_q;
    cur_mode_d = cur_mode_q;
    dir_d      = dir_q;
    if (tick) begin
      if (mode_sel != cur_mode_q) begin
        // A new mode only loads its start pattern; the first advance is on the following tick.
        cur_mode_d = mode_sel;
        dir_d      = DirUp;
        unique case (mode_sel)
          ModeCount:  pat_d = '0;
          ModeChase:  pat_d = NUM_LEDS'(1);
          ModeBounce: pat_d = NUM_LEDS'(1);
          ModeBlink:  pat_d = '1;
        endcase
      end else begin
        unique case (cur_mode_q)
          ModeCount: pat_d = pat_q + NUM_LEDS'(1);
          ModeChase: pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
          ModeBounce: begin
            if (dir_q == DirUp) begin
              if (pat_q[NUM_LEDS-1]) begin
                pat_d = pat_q >> 1;
                dir_d = DirDn;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                pat_d = pat_q << 1;
                dir_d = DirUp;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          ModeBlink: pat_d = ~pat_q;
        endcase
      end
    end
  end

  always_ff @(posedge clki_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q      <= '0;
      pat_q      <= '0;
      cur_mode_q <= ModeCount;
      dir_q      <= DirUp;
    end else begin
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      cur_mode_q <= cur_mode_d;
      dir_q      <= dir_d;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0]          pwm_cnt_q;
  logic [NUM_LEDS-1:0] led_q, led_d;

  assign led_d = pat_q & {NUM_LEDS{pwm_cnt_q < duty_i}};

  // PWM counter free-runs regardless of pause so dimming stays flicker-free while frozen.
  always_ff @(posedge clki_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      led_q     <= led_d;
    end
  end

  assign led_o = led_q;
`else
  assign led_o = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed, table-driven bench for led_pattern_gen with TICK_DIV=4, NUM_LEDS=5.
module tb_led_pattern_gen;

  logic       clk;
  logic       reset_n;
  logic [1:0] mode;
  logic       pause;
  logic       tick;
  logic [4:0] led;
  logic       prev_tick;
  int         total;
  int         bad;

  typedef struct {
    logic [1:0] mode;
    logic [4:0] exp_led;
    string      name;
  } vec_t;

  vec_t vecs[$];

  led_pattern_gen #(
    .NUM_LEDS (5),
    .TICK_DIV (4),
    .CNT_W    (3)
  ) dut (
    .clki_i   (clk),
    .reset_ni (reset_n),
    .mode_i   (mode),
    .pause_i  (pause),
`ifdef LED_PWM_EN
    .duty_i   (8'hff),
`endif
    .tick_o   (tick),
    .led_o    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; also guards against back-to-back ticks.
  task automatic cyc();
    @(posedge clk);
    #1;
    check("tick_gap", {31'b0, tick & prev_tick}, 32'd0);
    prev_tick = tick;
  endtask

  // One full step period starting right after a tick edge (cnt==0).
  task automatic period(input logic [1:0] m, input logic [4:0] exp, input string name);
    int t;
    mode = m;
    t = 0;
    repeat (4) begin
      cyc();
      if (tick) t++;
    end
    check({name, "_ticks"}, 32'(t), 32'd1);
    check(name, 32'(led), 32'(exp));
  endtask

  initial begin
    logic [4:0] frozen;
    total     = 0;
    bad       = 0;
    prev_tick = 1'b0;
    reset_n   = 1'b0;
    mode      = 2'd0;
    pause     = 1'b0;

    for (int k = 1; k <= 32; k++) vecs.push_back('{2'd0, 5'(k % 32), "count"});
    vecs.push_back('{2'd2, 5'd1,  "bounce_load"});
    vecs.push_back('{2'd2, 5'd2,  "bounce"});
    vecs.push_back('{2'd2, 5'd4,  "bounce"});
    vecs.push_back('{2'd2, 5'd8,  "bounce"});
    vecs.push_back('{2'd2, 5'd16, "bounce_top"});
    vecs.push_back('{2'd2, 5'd8,  "bounce_down"});
    vecs.push_back('{2'd2, 5'd4,  "bounce_down"});
    vecs.push_back('{2'd2, 5'd2,  "bounce_down"});
    vecs.push_back('{2'd2, 5'd1,  "bounce_bottom"});
    vecs.push_back('{2'd2, 5'd2,  "bounce_up"});
    vecs.push_back('{2'd1, 5'd1,  "chase_load"});
    vecs.push_back('{2'd1, 5'd2,  "chase"});
    vecs.push_back('{2'd1, 5'd4,  "chase"});
    vecs.push_back('{2'd1, 5'd8,  "chase"});
    vecs.push_back('{2'd1, 5'd16, "chase"});
    vecs.push_back('{2'd1, 5'd1,  "chase_wrap"});

    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'd0);
    check("reset_tick", {31'b0, tick}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) period(vecs[i].mode, vecs[i].exp_led, vecs[i].name);

    // Mode switch mid-period: led holds until the tick, then BLINK loads all ones.
    mode = 2'd1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (c == 0) mode = 2'd3;
      if (c < 3) check("blink_hold", 32'(led), 32'd1);
    end
    check("blink_load", 32'(led), 32'd31);
    period(2'd3, 5'd0, "blink");
    period(2'd3, 5'd31, "blink");

    // Mode toggled away and back between ticks is invisible.
    mode = 2'd3;
    cyc();
    mode = 2'd0;
    cyc();
    mode = 2'd3;
    cyc();
    cyc();
    check("toggle_unseen", 32'(led), 32'd0);

    // Pause asserted in the tick cycle suppresses the tick until release.
    cyc();
    cyc();
    cyc();
    check("pre_pause_tick", {31'b0, tick}, 32'd1);
    pause = 1'b1;
    #1;
    check("pause_kills_tick", {31'b0, tick}, 32'd0);
    frozen = led;
    for (int c = 0; c < 10; c++) begin
      cyc();
      check("pause_tick", {31'b0, tick}, 32'd0);
      check("pause_led", 32'(led), 32'(frozen));
    end
    pause = 1'b0;
    #1;
    check("release_tick", {31'b0, tick}, 32'd1);
    cyc();
    check("release_step", 32'(led), 32'd31);
    period(2'd3, 5'd0, "post_pause");

    // Asynchronous reset mid-cycle while bouncing at 01000.
    period(2'd2, 5'd1, "bounce2_load");
    period(2'd2, 5'd2, "bounce2");
    period(2'd2, 5'd4, "bounce2");
    period(2'd2, 5'd8, "bounce2");
    cyc();
    cyc();
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_tick", {31'b0, tick}, 32'd0);
    mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_led", 32'(led), 32'd0);
    reset_n   = 1'b1;
    prev_tick = 1'b0;
    period(2'd0, 5'd1, "restart_count");
    period(2'd0, 5'd2, "restart_count");
    period(2'd3, 5'd31, "restart_blink_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed 5-LED blinky on the iCE40 board top.
- Divides clki down to a pattern-step strobe and drives NUM_LEDS outputs with one of four runtime-selectable patterns: binary count, chase, bounce, blink.
- Instantiated by the chip top in place of the hard-wired blinky counter.
- Pause input and tick output make it usable as a slow system heartbeat.

Parameters:
- NUM_LEDS, 5, number of LED outputs; legal range 2..32.
- TICK_DIV, 900000, clki cycles per pattern step; legal range >= 2.
- CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clki  in  1  system clock.
- reset  in  1  asynchronous active-low reset (0 = in reset).
- mode  in  2  pattern select: 0 COUNT, 1 CHASE, 2 BOUNCE, 3 BLINK; sampled only on tick.
- pause  in  1  1 freezes prescaler and pattern.
- tick  out  1  one-cycle step strobe.
- led  out  NUM_LEDS  LED drive, active-high.

Behaviour:
- Reset (reset=0, asynchronous): cnt=0, pat=0, cur_mode=0 (COUNT), dir=UP, led=0, tick=0. Reset release is synchronous to clki.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps to 0 while pause=0; it holds its value while pause=1.
  - tick=1 exactly in cycles where cnt==TICK_DIV-1 and pause=0. Asserting pause in that cycle suppresses that tick; the tick occurs once pause is released.
  - tick is never high in two consecutive cycles.
- Step rule: all updates below happen on the rising edge that ends a tick=1 cycle.
  - If mode != cur_mode: cur_mode <= mode and pat <= init(mode); no advance on this tick.
    - init values: COUNT=0; CHASE=1; BOUNCE=1 with dir=UP; BLINK=all ones.
  - Otherwise pat advances per cur_mode:
    - COUNT: pat+1 modulo 2^NUM_LEDS; all ones wraps to 0.
    - CHASE: rotate left by 1; bit NUM_LEDS-1 wraps to bit 0.
    - BOUNCE, dir=UP: if pat[NUM_LEDS-1], then pat>>1 and dir<=DOWN; else pat<<1.
    - BOUNCE, dir=DOWN: if pat[0], then pat<<1 and dir<=UP; else pat>>1.
    - BOUNCE end LEDs are lit for one step only. For N=5 the sequence is 1,2,4,8,16,8,4,2,1,2,...
    - BLINK: pat <= ~pat.
- Output: led = pat with no extra latency (feature off). The first led change after reset release occurs TICK_DIV edges after release.
- mode changes between ticks have no effect until the next tick. A mode toggled away and back between two ticks is not seen.
- Reset mid-operation clears all state immediately, regardless of pause or mode.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Adds input port duty [7:0] and an 8-bit free-running pwm_cnt (reset 0, increments every clki cycle, wraps 255->0, not affected by pause).
  - led is registered as led[i] <= pat[i] & (pwm_cnt < duty), adding 1 cycle of latency.
  - duty=0 gives all LEDs dark. duty=255 gives a lit LED on for 255 of 256 cycles.
  - Reset clears led to 0.
- Undefined: no duty port, no pwm_cnt, led = pat combinationally as above.

Test Plan:
- TICK_DIV=4, NUM_LEDS=5, mode=0, hold reset=0 for 2 cycles, then release -> tick every 4th cycle; led steps 0,1,2,...,31,0 over successive ticks.
- mode=2 applied before the first tick -> first tick loads led=00001; subsequent ticks give 2,4,8,16,8,4,2,1,2.
- CHASE running at led=10000, one tick -> led=00001. Switch mode to BLINK mid-period -> led unchanged until next tick, then led=11111, then 00000, then 11111.
- pause=1 held when cnt==3 -> tick stays 0 and led frozen for 10 cycles; release pause -> tick fires in the first cycle after release.
- Assert reset=0 asynchronously mid-cycle during BOUNCE at led=01000 -> led=0 and tick=0 immediately, without waiting for a clock edge; after release, mode=COUNT restarts and cur_mode is reloaded from mode at the first tick.
- LED_PWM_EN defined, pat=11111, duty=64 -> each led high exactly 64 of every 256 cycles; duty=0 -> led held 0.
